// File: rtl/hazard_ctl.sv
// Pipeline hazard controller: tracks EX/MEM destinations for forwarding, detects
// load-use and mult/div (HI/LO) hazards, and produces the ID-stage stall.
module hazard_ctl #(
    parameter int MD_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      id_rns,
    input  logic [4:0]      id_rnt,
    input  logic            id_uses_rs,
    input  logic            id_uses_rt,
    input  logic [4:0]      id_wr_rn,
    input  logic            id_we,
    input  logic            id_is_load,
    input  logic            id_is_md,
    input  logic            id_rd_hilo,
    input  logic [MD_W-1:0] md_len,
    input  logic            flush,
    output logic [4:0]      fw_alu_rn,
    output logic            alu_we,
    output logic [4:0]      fw_mem_rn,
    output logic            mem_We,
    output logic            stall,
    output logic            md_busy,
    output logic [15:0]     stall_cnt
);

    localparam logic [MD_W-1:0] MD_ZERO = '0;
    localparam logic [MD_W-1:0] MD_ONE  = {{(MD_W-1){1'b0}}, 1'b1};

    logic [4:0]      ex_rn;
    logic            ex_we;
    logic            ex_load;
    logic [4:0]      mem_rn;
    logic            mem_we_r;
    logic [MD_W-1:0] md_cnt;
    logic            lu_haz;
    logic            md_haz;
    logic            advance;

    // r0 is hardwired zero, so a load targeting it can never create a hazard.
    always_comb begin
        lu_haz = ex_load && ex_we && (ex_rn != 5'd0) &&
                 ((id_uses_rs && (id_rns == ex_rn)) ||
                  (id_uses_rt && (id_rnt == ex_rn)));
        md_haz  = (md_cnt != MD_ZERO) && (id_rd_hilo || id_is_md);
        stall   = (lu_haz || md_haz) && !flush;
        advance = !stall && !flush;
    end

    // A stalled or flushed ID instruction enters EX as a bubble; ex_rn is kept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_rn   <= 5'd0;
            ex_we   <= 1'b0;
            ex_load <= 1'b0;
        end else if (advance) begin
            ex_rn   <= id_wr_rn;
            ex_we   <= id_we;
            ex_load <= id_is_load;
        end else begin
            ex_we   <= 1'b0;
            ex_load <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_rn   <= 5'd0;
            mem_we_r <= 1'b0;
        end else begin
            mem_rn   <= ex_rn;
            mem_we_r <= ex_we;
        end
    end

    // A flush only blocks a new load; an already-running mult/div keeps counting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            md_cnt <= MD_ZERO;
        end else if (id_is_md && advance) begin
            md_cnt <= md_len;
        end else if (md_cnt != MD_ZERO) begin
            md_cnt <= md_cnt - MD_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= 16'd0;
        end else if (stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign fw_alu_rn = ex_rn;
    assign alu_we    = ex_we && !ex_load;
    assign fw_mem_rn = mem_rn;
    assign mem_We    = mem_we_r;
    assign md_busy   = (md_cnt != MD_ZERO);

endmodule

// File: tb/tb_hazard_ctl.sv
// Directed bench for hazard_ctl: a per-cycle vector table with hand-computed
// outputs, followed by an asynchronous reset taken in the middle of a mult/div.
module tb_hazard_ctl;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rns;
    logic [4:0]  id_rnt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic [4:0]  id_wr_rn;
    logic        id_we;
    logic        id_is_load;
    logic        id_is_md;
    logic        id_rd_hilo;
    logic [5:0]  md_len;
    logic        flush;
    logic [4:0]  fw_alu_rn;
    logic        alu_we;
    logic [4:0]  fw_mem_rn;
    logic        mem_We;
    logic        stall;
    logic        md_busy;
    logic [15:0] stall_cnt;

    int checks;
    int errors;

    hazard_ctl #(.MD_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .id_rns     (id_rns),
        .id_rnt     (id_rnt),
        .id_uses_rs (id_uses_rs),
        .id_uses_rt (id_uses_rt),
        .id_wr_rn   (id_wr_rn),
        .id_we      (id_we),
        .id_is_load (id_is_load),
        .id_is_md   (id_is_md),
        .id_rd_hilo (id_rd_hilo),
        .md_len     (md_len),
        .flush      (flush),
        .fw_alu_rn  (fw_alu_rn),
        .alu_we     (alu_we),
        .fw_mem_rn  (fw_mem_rn),
        .mem_We     (mem_We),
        .stall      (stall),
        .md_busy    (md_busy),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rns;
        logic        urs;
        logic [4:0]  rnt;
        logic        urt;
        logic [4:0]  wr;
        logic        we;
        logic        ld;
        logic        md;
        logic        hl;
        logic [5:0]  len;
        logic        fl;
        logic [4:0]  e_alu_rn;
        logic        e_alu_we;
        logic [4:0]  e_mem_rn;
        logic        e_mem_we;
        logic        e_stall;
        logic        e_busy;
        logic [15:0] e_cnt;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs[NV];

    function automatic vec_t mk(
        input logic [4:0] rns, input logic urs, input logic [4:0] rnt, input logic urt,
        input logic [4:0] wr, input logic we, input logic ld, input logic md,
        input logic hl, input logic [5:0] len, input logic fl,
        input logic [4:0] e_alu_rn, input logic e_alu_we,
        input logic [4:0] e_mem_rn, input logic e_mem_we,
        input logic e_stall, input logic e_busy, input logic [15:0] e_cnt);
        vec_t v;
        v.rns = rns; v.urs = urs; v.rnt = rnt; v.urt = urt;
        v.wr = wr; v.we = we; v.ld = ld; v.md = md; v.hl = hl; v.len = len; v.fl = fl;
        v.e_alu_rn = e_alu_rn; v.e_alu_we = e_alu_we;
        v.e_mem_rn = e_mem_rn; v.e_mem_we = e_mem_we;
        v.e_stall = e_stall; v.e_busy = e_busy; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d actual %0h required %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        id_rns     = v.rns;
        id_uses_rs = v.urs;
        id_rnt     = v.rnt;
        id_uses_rt = v.urt;
        id_wr_rn   = v.wr;
        id_we      = v.we;
        id_is_load = v.ld;
        id_is_md   = v.md;
        id_rd_hilo = v.hl;
        md_len     = v.len;
        flush      = v.fl;
    endtask

    task automatic check_vec(input vec_t v, input int idx);
        chk("fw_alu_rn", idx, 32'(fw_alu_rn), 32'(v.e_alu_rn));
        chk("alu_we",    idx, 32'(alu_we),    32'(v.e_alu_we));
        chk("fw_mem_rn", idx, 32'(fw_mem_rn), 32'(v.e_mem_rn));
        chk("mem_We",    idx, 32'(mem_We),    32'(v.e_mem_we));
        chk("stall",     idx, 32'(stall),     32'(v.e_stall));
        chk("md_busy",   idx, 32'(md_busy),   32'(v.e_busy));
        chk("stall_cnt", idx, 32'(stall_cnt), 32'(v.e_cnt));
    endtask

    vec_t nop_v;
    vec_t mult5_v;
    vec_t mfhi_v;
    vec_t lu_v;

    initial begin
        checks = 0;
        errors = 0;

        //               rns urs rnt urt wr  we ld md hl len fl | alu ae mem me st bz cnt
        vecs[0]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0, 0);  // nop
        vecs[1]  = mk(0, 0, 0, 0, 3,  1, 0, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0, 0);  // add r3
        vecs[2]  = mk(3, 1, 0, 0, 7,  1, 0, 0, 0, 0, 0,   3, 1, 0,  0, 0, 0, 0);  // or r7,r3
        vecs[3]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,   7, 1, 3,  1, 0, 0, 0);
        vecs[4]  = mk(0, 0, 0, 0, 5,  1, 1, 0, 0, 0, 0,   0, 0, 7,  1, 0, 0, 0);  // lw r5
        vecs[5]  = mk(5, 1, 0, 0, 6,  1, 0, 0, 0, 0, 0,   5, 0, 0,  0, 1, 0, 0);  // add rs=r5
        vecs[6]  = mk(5, 1, 0, 0, 6,  1, 0, 0, 0, 0, 0,   5, 0, 5,  1, 0, 0, 1);
        vecs[7]  = mk(0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0,   6, 1, 5,  0, 0, 0, 1);  // lw r0
        vecs[8]  = mk(0, 1, 0, 1, 8,  1, 0, 0, 0, 0, 0,   0, 0, 6,  1, 0, 0, 1);  // reads r0
        vecs[9]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,   8, 1, 0,  1, 0, 0, 1);
        vecs[10] = mk(0, 0, 0, 0, 9,  1, 1, 0, 0, 0, 0,   0, 0, 8,  1, 0, 0, 1);  // lw r9
        vecs[11] = mk(0, 0, 9, 1, 4,  1, 0, 0, 0, 0, 1,   9, 0, 0,  0, 0, 0, 1);  // rt=r9, flush
        vecs[12] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,   9, 0, 9,  1, 0, 0, 1);
        vecs[13] = mk(0, 0, 0, 0, 2,  1, 1, 0, 0, 0, 0,   0, 0, 9,  0, 0, 0, 1);  // lw r2
        vecs[14] = mk(2, 0, 1, 1, 0,  0, 0, 0, 0, 0, 0,   2, 0, 0,  0, 0, 0, 1);  // rs=r2 unused
        vecs[15] = mk(0, 0, 0, 0, 0,  0, 0, 1, 0, 4, 0,   0, 0, 2,  1, 0, 0, 1);  // mult len 4
        vecs[16] = mk(0, 0, 0, 0, 10, 1, 0, 0, 1, 0, 0,   0, 0, 0,  0, 1, 1, 1);  // mfhi
        vecs[17] = mk(0, 0, 0, 0, 10, 1, 0, 0, 1, 0, 0,   0, 0, 0,  0, 1, 1, 2);
        vecs[18] = mk(0, 0, 0, 0, 10, 1, 0, 0, 1, 0, 0,   0, 0, 0,  0, 1, 1, 3);
        vecs[19] = mk(0, 0, 0, 0, 10, 1, 0, 0, 1, 0, 0,   0, 0, 0,  0, 1, 1, 4);
        vecs[20] = mk(0, 0, 0, 0, 10, 1, 0, 0, 1, 0, 0,   0, 0, 0,  0, 0, 0, 5);
        vecs[21] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  10, 1, 0,  0, 0, 0, 5);
        vecs[22] = mk(0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0,   0, 0, 10, 1, 0, 0, 5);  // mult len 0
        vecs[23] = mk(0, 0, 0, 0, 10, 1, 0, 0, 1, 0, 0,   0, 0, 0,  0, 0, 0, 5);  // mfhi, no wait
        vecs[24] = mk(0, 0, 0, 0, 0,  0, 0, 1, 0, 2, 0,  10, 1, 0,  0, 0, 0, 5);  // mult len 2
        vecs[25] = mk(0, 0, 0, 0, 0,  0, 0, 1, 0, 3, 0,   0, 0, 10, 1, 1, 1, 5);  // mult behind mult
        vecs[26] = mk(0, 0, 0, 0, 0,  0, 0, 1, 0, 3, 1,   0, 0, 0,  0, 0, 1, 6);  // same, flushed
        vecs[27] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,   0, 0, 0,  0, 0, 0, 6);

        nop_v   = vecs[0];
        mult5_v = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 5, 0,  0, 0, 0, 0, 0, 0, 0);
        mfhi_v  = mk(0, 0, 0, 0, 10, 1, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        lu_v    = mk(5, 1, 5, 1, 6, 1, 1, 1, 1, 7, 0,  0, 0, 0, 0, 0, 0, 0);

        // Reset with hazard-looking inputs: everything must read zero.
        rst = 1'b0;
        drive(lu_v);
        #12;
        chk("rst_stall",     -1, 32'(stall),     32'd0);
        chk("rst_alu_we",    -1, 32'(alu_we),    32'd0);
        chk("rst_mem_We",    -1, 32'(mem_We),    32'd0);
        chk("rst_fw_alu_rn", -1, 32'(fw_alu_rn), 32'd0);
        chk("rst_fw_mem_rn", -1, 32'(fw_mem_rn), 32'd0);
        chk("rst_md_busy",   -1, 32'(md_busy),   32'd0);
        chk("rst_stall_cnt", -1, 32'(stall_cnt), 32'd0);
        drive(nop_v);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check_vec(vecs[i], i);
        end

        // Reset taken asynchronously while mfhi waits on a mult/div with md_cnt=3.
        @(negedge clk);
        drive(mult5_v);
        #1;
        chk("md_issue_stall", 100, 32'(stall), 32'd0);
        @(negedge clk);
        drive(mfhi_v);
        #1;
        chk("md5_stall", 101, 32'(stall), 32'd1);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("md3_busy",      102, 32'(md_busy),   32'd1);
        chk("md3_stall",     102, 32'(stall),     32'd1);
        chk("md3_stall_cnt", 102, 32'(stall_cnt), 32'd8);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_busy",      103, 32'(md_busy),   32'd0);
        chk("arst_stall",     103, 32'(stall),     32'd0);
        chk("arst_stall_cnt", 103, 32'(stall_cnt), 32'd0);
        chk("arst_mem_We",    103, 32'(mem_We),    32'd0);
        @(negedge clk);
        chk("hold_rst_stall", 104, 32'(stall), 32'd0);
        rst = 1'b1;
        #1;
        chk("post_rst_stall", 105, 32'(stall),   32'd0);
        chk("post_rst_busy",  105, 32'(md_busy), 32'd0);
        drive(lu_v);
        #1;
        chk("post_rst_lu_stall", 106, 32'(stall), 32'd0);
        @(negedge clk);
        drive(nop_v);
        #1;
        chk("post_rst_cnt", 107, 32'(stall_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctl.md
HAZARD_CTL -- requirements
Module: hazard_ctl

Interface
REQ-001 SHALL have parameter MD_W, default 6, giving the width of the multiply/divide latency counter.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have ports id_rns and id_rnt, input, 5 bits each: the source register numbers of the instruction in ID.
REQ-005 SHALL have ports id_uses_rs and id_uses_rt, input, 1 bit each: the ID instruction actually reads that source.
REQ-006 SHALL have port id_wr_rn, input, 5 bits: destination register number of the ID instruction.
REQ-007 SHALL have port id_we, input, 1 bit: the ID instruction writes the register file.
REQ-008 SHALL have port id_is_load, input, 1 bit: the ID instruction is a load.
REQ-009 SHALL have port id_is_md, input, 1 bit: the ID instruction starts a mult/div.
REQ-010 SHALL have port id_rd_hilo, input, 1 bit: the ID instruction reads HI/LO.
REQ-011 SHALL have port md_len, input, MD_W bits: busy cycles of the mult/div being issued.
REQ-012 SHALL have port flush, input, 1 bit: branch/exception flush of the ID instruction.
REQ-013 SHALL have ports fw_alu_rn, output, 5 bits, and alu_we, output, 1 bit: the EX-stage destination and write-enable fed to the forwarding unit.
REQ-014 SHALL have ports fw_mem_rn, output, 5 bits, and mem_We, output, 1 bit: the MEM-stage destination and write-enable fed to the forwarding unit.
REQ-015 SHALL have port stall, output, 1 bit: hold PC, IF/ID and the ID stage.
REQ-016 SHALL have port md_busy, output, 1 bit: the mult/div counter is nonzero.
REQ-017 SHALL have port stall_cnt, output, 16 bits: saturating count of stall cycles.

Function
REQ-018 SHALL hold EX-stage registers ex_rn[4:0], ex_we and ex_load; each cycle, when stall=0 and flush=0, they load id_wr_rn, id_we and id_is_load.
REQ-019 SHALL insert a bubble when stall=1 or flush=1: ex_we=0 and ex_load=0, with ex_rn unchanged.
REQ-020 SHALL advance the MEM stage unconditionally each cycle: mem_rn<=ex_rn and mem_we_r<=ex_we.
REQ-021 SHALL drive fw_alu_rn=ex_rn and alu_we=ex_we&~ex_load, because a load result is not available for ALU forwarding.
REQ-022 SHALL drive fw_mem_rn=mem_rn and mem_We=mem_we_r.
REQ-023 SHALL assert the combinational term lu_haz when ex_load&ex_we&(ex_rn!=0) and either (id_uses_rs&id_rns==ex_rn) or (id_uses_rt&id_rnt==ex_rn).
REQ-024 SHALL load md_cnt with md_len when id_is_md=1, stall=0 and flush=0; otherwise, while md_cnt!=0, decrement it by 1 per cycle.
REQ-025 SHALL keep md_cnt at 0 when md_len=0, leaving md_busy low.
REQ-026 SHALL assert md_haz when (md_cnt!=0) and (id_rd_hilo or id_is_md).
REQ-027 SHALL drive stall=(lu_haz|md_haz)&~flush as a combinational output with zero-cycle latency.
REQ-028 SHALL let flush take priority over stall.
REQ-029 SHALL leave an in-flight md_cnt unaffected by flush.
REQ-030 SHALL limit a load-use stall to exactly 1 cycle, since the bubble clears ex_load.
REQ-031 SHALL drive md_busy=(md_cnt!=0).
REQ-032 SHALL increment stall_cnt on each cycle with stall=1 and saturate it at 16'hFFFF.
REQ-033 SHALL never raise a hazard when the matching register number is 0.

Reset
REQ-034 SHALL, while rst=0, asynchronously clear ex_rn, ex_we, ex_load, mem_rn, mem_we_r, md_cnt and stall_cnt to 0; all outputs are then 0, and stall=0 for any inputs.
REQ-035 SHALL, on rst assertion mid-operation (during a stall or mult/div busy), abandon all state immediately with no residual stall after deassertion.

Verification
REQ-036 SHALL cover load-use: lw to r5, then add reading rs=r5 -> stall=1 for exactly 1 cycle, alu_we=0 that cycle; the next cycle mem_We=1 with fw_mem_rn=5; stall_cnt=1.
REQ-037 SHALL cover the r0 case: lw to r0 followed by a reader of r0 -> stall=0 throughout.
REQ-038 SHALL cover ALU pipe: add r3 issued -> next cycle fw_alu_rn=3, alu_we=1; the cycle after, fw_mem_rn=3, mem_We=1, alu_we per the following instruction.
REQ-039 SHALL cover mult/div: mult with md_len=4, then mfhi presented immediately -> stall=1 for 4 cycles and md_busy high for 4 cycles, then the mfhi advances.
REQ-040 SHALL cover flush: a load-use hazard with flush=1 in the same cycle -> stall=0, and EX receives a bubble (alu_we=0 next cycle).
REQ-041 SHALL cover reset: rst driven low during a mult/div busy with md_cnt=3 -> md_busy=0, stall=0 and stall_cnt=0 immediately, without waiting for clk.
